// File: rtl/uart_rx_byte_fifo.sv
// 8N1 UART receiver with mid-bit sampling and start-glitch rejection,
// feeding a first-word-fall-through byte FIFO on a valid/ready port.
module uart_rx_byte_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             i_Clk,
    input  logic                             rst,
    input  logic                             i_UART_RX,
    output logic [7:0]                       o_Data,
    output logic                             o_Valid,
    input  logic                             i_Ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_Count,
    output logic                             o_Framing_Err,
    output logic                             o_Overflow
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] DEPTH   = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic             rx_meta_q, rx_s_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push, fe_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic              fe_q, ovf_q;
    logic              pop, full, wr_en, ovf_d;

    always_ff @(posedge i_Clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= i_UART_RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        fe_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    push      = rx_s_q;
                    fe_d      = !rx_s_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full  = (count_q == DEPTH);
    assign pop   = o_Valid && i_Ready;
    assign wr_en = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    always_ff @(posedge i_Clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fe_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            fe_q  <= fe_d;
            ovf_q <= ovf_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign o_Valid       = (count_q != '0);
    assign o_Data        = o_Valid ? mem_q[rd_ptr_q] : 8'h00;
    assign o_Count       = count_q;
    assign o_Framing_Err = fe_q;
    assign o_Overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Directed bench for uart_rx_byte_fifo with a short bit period:
// latency, stall/back-to-back, framing, glitch, overflow and reset cases.
module tb_uart_rx_byte_fifo;

    localparam int C   = 16;
    localparam int D   = 4;
    localparam int LAT = 3 + C / 2 + 9 * C;
    localparam int SAMPLE_STOP = 2 + C / 2 + 9 * C;

    logic       i_Clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_UART_RX = 1'b1;
    logic [7:0] o_Data;
    logic       o_Valid;
    logic       i_Ready = 1'b0;
    logic [2:0] o_Count;
    logic       o_Framing_Err;
    logic       o_Overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_hs_cyc = 0;
    logic [7:0] last_hs_data = 8'h00;

    uart_rx_byte_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_Clk(i_Clk), .rst(rst), .i_UART_RX(i_UART_RX),
        .o_Data(o_Data), .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_Count(o_Count), .o_Framing_Err(o_Framing_Err),
        .o_Overflow(o_Overflow)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    always @(negedge i_Clk) begin
        if (rst) begin
            if (o_Valid && i_Ready) begin
                hs_cnt++;
                last_hs_cyc  = cyc;
                last_hs_data = o_Data;
            end
            if (o_Framing_Err) fe_cnt++;
            if (o_Overflow) ov_cnt++;
        end
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    // rdy_at >= 0 raises i_Ready for exactly one cycle, rdy_at cycles in
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int rdy_at);
        int n;
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        n = 0;
        for (int b = 0; b < 10; b++) begin
            i_UART_RX = bits[b];
            for (int k = 0; k < C; k++) begin
                tick();
                n++;
                if (n == rdy_at) i_Ready = 1'b1;
                else if (rdy_at >= 0 && n == rdy_at + 1) i_Ready = 1'b0;
            end
        end
        i_UART_RX = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (50) tick();
        checks += 5;
        if (o_Valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", o_Valid);
        end
        if (o_Count !== 3'd0) begin
            errors++; $display("FAIL reset_count got=%0d want=0", o_Count);
        end
        if (o_Data !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%h want=00", o_Data);
        end
        if (o_Framing_Err !== 1'b0) begin
            errors++; $display("FAIL reset_fe got=%b want=0", o_Framing_Err);
        end
        if (o_Overflow !== 1'b0) begin
            errors++; $display("FAIL reset_ovf got=%b want=0", o_Overflow);
        end
        rst = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_single();
        int hs0, start;
        i_Ready = 1'b1;
        hs0 = hs_cnt;
        start = cyc;
        send_frame(8'hC3, 1'b1, -1);
        repeat (4) tick();
        checks += 4;
        if (hs_cnt - hs0 != 1) begin
            errors++; $display("FAIL single_count got=%0d want=1", hs_cnt - hs0);
        end
        if (last_hs_data !== 8'hC3) begin
            errors++; $display("FAIL single_data got=%h want=c3", last_hs_data);
        end
        if (last_hs_cyc - start != LAT) begin
            errors++;
            $display("FAIL single_latency got=%0d want=%0d",
                     last_hs_cyc - start, LAT);
        end
        if (o_Count !== 3'd0) begin
            errors++; $display("FAIL single_empty got=%0d want=0", o_Count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{8'h5A, 8'h99, 8'hB3};
        i_Ready = 1'b0;
        send_frame(8'h5A, 1'b1, -1);
        send_frame(8'h99, 1'b1, -1);
        send_frame(8'hB3, 1'b1, -1);
        repeat (2) tick();
        checks++;
        if (o_Count !== 3'd3) begin
            errors++; $display("FAIL b2b_count got=%0d want=3", o_Count);
        end
        i_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if (o_Data !== exp[i]) begin
                errors++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, o_Data, exp[i]);
            end
            if (o_Count !== 3'(3 - i)) begin
                errors++; $display("FAIL b2b_cnt[%0d] got=%0d want=%0d", i, o_Count, 3 - i);
            end
            tick();
        end
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drained got=%b want=0", o_Valid);
        end
    endtask

    task automatic test_framing();
        int fe0, hs0;
        i_Ready = 1'b1;
        fe0 = fe_cnt;
        hs0 = hs_cnt;
        send_frame(8'h99, 1'b0, -1);
        repeat (2 * C) tick();
        checks += 3;
        if (fe_cnt - fe0 != 1) begin
            errors++; $display("FAIL fe_pulse got=%0d want=1", fe_cnt - fe0);
        end
        if (hs_cnt - hs0 != 0) begin
            errors++; $display("FAIL fe_nobyte got=%0d want=0", hs_cnt - hs0);
        end
        if (o_Count !== 3'd0) begin
            errors++; $display("FAIL fe_count got=%0d want=0", o_Count);
        end
        send_frame(8'h11, 1'b1, -1);
        repeat (4) tick();
        checks += 2;
        if (hs_cnt - hs0 != 1 || last_hs_data !== 8'h11) begin
            errors++;
            $display("FAIL fe_next got=%h n=%0d want=11 n=1", last_hs_data, hs_cnt - hs0);
        end
        if (fe_cnt - fe0 != 1) begin
            errors++; $display("FAIL fe_next_clean got=%0d want=1", fe_cnt - fe0);
        end
    endtask

    task automatic test_glitch();
        int fe0, hs0, ov0, start;
        i_Ready = 1'b1;
        fe0 = fe_cnt; hs0 = hs_cnt; ov0 = ov_cnt;
        i_UART_RX = 1'b0;
        repeat (C / 4) tick();
        i_UART_RX = 1'b1;
        repeat (2 * C) tick();
        checks += 2;
        if (hs_cnt != hs0 || o_Count !== 3'd0) begin
            errors++; $display("FAIL glitch_valid got=%0d want=0", hs_cnt - hs0);
        end
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            errors++; $display("FAIL glitch_err got=%0d want=0", fe_cnt - fe0);
        end
        start = cyc;
        send_frame(8'hA5, 1'b1, -1);
        repeat (4) tick();
        checks += 2;
        if (last_hs_data !== 8'hA5 || hs_cnt - hs0 != 1) begin
            errors++; $display("FAIL glitch_next got=%h want=a5", last_hs_data);
        end
        if (last_hs_cyc - start != LAT) begin
            errors++;
            $display("FAIL glitch_idle_lat got=%0d want=%0d", last_hs_cyc - start, LAT);
        end
    endtask

    task automatic test_overflow();
        int ov0;
        logic [7:0] exp [4];
        i_Ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h9A, 1'b1, -1);
        send_frame(8'h77, 1'b1, -1);
        send_frame(8'h28, 1'b1, -1);
        send_frame(8'hAA, 1'b1, -1);
        repeat (2) tick();
        checks += 3;
        if (ov_cnt - ov0 != 1) begin
            errors++; $display("FAIL ovf_pulse got=%0d want=1", ov_cnt - ov0);
        end
        if (o_Count !== 3'd4) begin
            errors++; $display("FAIL ovf_count got=%0d want=4", o_Count);
        end
        if (o_Data !== 8'h11) begin
            errors++; $display("FAIL ovf_head got=%h want=11", o_Data);
        end
        exp = '{8'h11, 8'h9A, 8'h77, 8'h28};
        i_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_Data !== exp[i]) begin
                errors++; $display("FAIL ovf_drain[%0d] got=%h want=%h", i, o_Data, exp[i]);
            end
            tick();
        end
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drained got=%b want=0", o_Valid);
        end

        i_Ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h9A, 1'b1, -1);
        send_frame(8'h77, 1'b1, -1);
        send_frame(8'h28, 1'b1, -1);
        send_frame(8'hAA, 1'b1, SAMPLE_STOP);
        repeat (2) tick();
        checks += 2;
        if (ov_cnt - ov0 != 0) begin
            errors++; $display("FAIL wrap_noovf got=%0d want=0", ov_cnt - ov0);
        end
        if (o_Count !== 3'd4) begin
            errors++; $display("FAIL wrap_count got=%0d want=4", o_Count);
        end
        exp = '{8'h9A, 8'h77, 8'h28, 8'hAA};
        i_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_Data !== exp[i]) begin
                errors++; $display("FAIL wrap_drain[%0d] got=%h want=%h", i, o_Data, exp[i]);
            end
            tick();
        end
        checks++;
        if (o_Valid !== 1'b0) begin
            errors++; $display("FAIL wrap_drained got=%b want=0", o_Valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        int hs0;
        logic [7:0] d;
        d = 8'hC3;
        i_Ready = 1'b0;
        send_frame(8'h3C, 1'b1, -1);
        repeat (2) tick();
        checks++;
        if (o_Count !== 3'd1) begin
            errors++; $display("FAIL rmid_pre got=%0d want=1", o_Count);
        end
        i_UART_RX = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            i_UART_RX = d[i];
            repeat (C) tick();
        end
        i_UART_RX = d[4];
        repeat (C / 2) tick();
        rst = 1'b0;
        tick();
        checks += 3;
        if (o_Valid !== 1'b0 || o_Count !== 3'd0) begin
            errors++;
            $display("FAIL rmid_fifo got=%b/%0d want=0/0", o_Valid, o_Count);
        end
        if (o_Data !== 8'h00) begin
            errors++; $display("FAIL rmid_data got=%h want=00", o_Data);
        end
        if (o_Framing_Err !== 1'b0 || o_Overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pulses got=%b%b want=00", o_Framing_Err, o_Overflow);
        end
        i_UART_RX = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        i_Ready = 1'b1;
        hs0 = hs_cnt;
        send_frame(8'h5A, 1'b1, -1);
        repeat (4) tick();
        checks++;
        if (hs_cnt - hs0 != 1 || last_hs_data !== 8'h5A) begin
            errors++;
            $display("FAIL rmid_next got=%h n=%0d want=5a n=1", last_hs_data, hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_overflow();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte_fifo.md
# uart_rx_byte_fifo

UART receive front end for the loopback path: it deserializes 8N1 frames arriving on the pin and buffers the completed bytes in a small FIFO. Bytes are presented on a valid/ready interface to the downstream transmit stage. It samples at mid-bit, rejects start-bit glitches, flags framing errors and overflow, and lets the consumer stall without losing back-to-back frames.

## Interface
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200); legal range 8..65535.
- FIFO_DEPTH, 4: byte entries; power of two, ≥ 2.
- i_Clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset; synchronous, active-low. rst=0 resets on the next i_Clk edge.
- i_UART_RX  input  1  asynchronous serial line; idles high.
- o_Data  output  8  byte at the FIFO head; valid only while o_Valid=1.
- o_Valid  output  1  FIFO is not empty.
- i_Ready  input  1  consumer accepts o_Data this cycle.
- o_Count  output  $clog2(FIFO_DEPTH+1)  number of bytes held.
- o_Framing_Err  output  1  one-cycle pulse: stop bit was sampled low.
- o_Overflow  output  1  one-cycle pulse: a good byte was dropped because the FIFO was full.

## Operation
- Input synchronizer: two flops on i_UART_RX, both reset to 1. The FSM uses only the synchronized value `rx_s`.
- Bit counter: `clk_cnt` has width $clog2(CLKS_PER_BIT). Index `bit_idx` is 0..7.
- FSM states are IDLE, START, DATA, STOP. Reset state is IDLE.
  - IDLE: `clk_cnt`=0. When rx_s=0, go to START.
  - START: count up to CLKS_PER_BIT/2−1 (integer division), then sample rx_s.
    - rx_s=0: go to DATA with `clk_cnt`=0 and `bit_idx`=0.
    - rx_s=1: treat as a glitch and return to IDLE. Nothing is reported.
  - DATA: count to CLKS_PER_BIT−1, then sample rx_s into `shift[bit_idx]` (LSB first) and clear `clk_cnt`. After bit 7, go to STOP.
  - STOP: count to CLKS_PER_BIT−1, then sample rx_s.
    - rx_s=1: push `shift`.
    - rx_s=0: pulse o_Framing_Err and discard the byte.
    - In both cases go straight to IDLE. There is no wait for the end of the stop bit, so back-to-back frames are caught.
- FIFO is first-word-fall-through, with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Push and pop are decided in the same cycle. A pop happens when o_Valid && i_Ready.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and o_Overflow pulses.
  - Push and pop in the same cycle: o_Count is unchanged and data ordering is preserved.
  - Pop while empty is ignored (i_Ready is don't-care while o_Valid=0).
  - FIFO contents are not affected by framing errors.
- Reset in the middle of a frame aborts it:
  - FSM returns to IDLE, and the FIFO pointers and count clear.
  - Synchronizer flops return to 1.
  - The next falling edge after rst returns high starts a fresh frame.

## Timing
- Reset values: o_Valid=0, o_Count=0, o_Data=0, o_Framing_Err=0, o_Overflow=0.
- Synchronizer latency is 2 cycles from the pin to rx_s.
- Sample points, measured from the first cycle rx_s=0:
  - start-bit check at CLKS_PER_BIT/2 cycles;
  - data bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Push latency: o_Valid and o_Count update on the cycle after the stop-bit sample. The o_Framing_Err and o_Overflow pulses fall on that same cycle.
- Pop: o_Data advances to the next entry and o_Count decrements on the cycle after the o_Valid && i_Ready handshake.
- Throughput: one byte per 10 bit periods is sustained indefinitely with i_Ready=1.

## Test plan
- Single byte: rst low for 50 cycles, then high; send 0xC3 with i_Ready=1. Expect one o_Valid pulse with o_Data=0xC3, at 2+CLKS_PER_BIT/2+9·CLKS_PER_BIT+1 cycles after the start edge. o_Count returns to 0.
- Back-to-back with stall: send 0x5A, 0x99, 0xB3 with no idle gap while i_Ready=0. Expect o_Count=3. Then raise i_Ready and expect 0x5A, 0x99, 0xB3 in that order, one per cycle, and o_Valid=0 afterwards.
- Framing error: send 0x99 with the stop bit driven 0. Expect o_Framing_Err to pulse for 1 cycle and o_Count to stay 0. A following 0x11 frame is received correctly.
- Glitch rejection: drive i_UART_RX low for CLKS_PER_BIT/4 cycles, then high. Expect no o_Valid, no error pulse, and the FSM back in IDLE.
- Overflow and wrap: with i_Ready=0, send 0x11, 0x9A, 0x77, 0x28, then 0xAA.
  - 0xAA is dropped: o_Overflow pulses and o_Count stays 4.
  - Repeat with i_Ready pulsed on the push cycle of 0xAA: it is accepted and the drain order is 0x9A, 0x77, 0x28, 0xAA.
- Reset mid-frame: assert rst during data bit 4 of 0xC3. Expect all outputs at reset values the next cycle. A subsequent 0x5A frame is received correctly.
